// File: rtl/jctrl_pkg.sv
// Shared types and constants for the jump/redirect controller.
// Holds the FSM state enum, the jmp_type encodings, the JR decode constant
// and the cause encoding, plus the decode helper used by the top level.
package jctrl_pkg;

    // Controller FSM states; IDLE must encode to zero so reset lands there.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_FLUSH    = 2'b10
    } state_e;

    // Encodings of the jmp_type field from the main decoder; 2'b11 is
    // reserved and behaves like NONE.
    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_J    = 2'b01,
        JMP_JAL  = 2'b10
    } jmp_type_e;

    // {ula_opcode, func} pattern that identifies a JR instruction.
    localparam logic [5:0] JR_DECODE = 6'b000000;

    // Why a redirect was taken.
    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_JR   = 2'b01,
        CAUSE_J    = 2'b10,
        CAUSE_JAL  = 2'b11
    } cause_e;

    // Classify the instruction in decode; JR wins over whatever jmp_type says.
    function automatic cause_e decode_cause(
        input logic [1:0] ula_opcode,
        input logic [3:0] func,
        input logic [1:0] jmp_type
    );
        cause_e c;
        c = CAUSE_NONE;
        if ({ula_opcode, func} == JR_DECODE) begin
            c = CAUSE_JR;
        end else if (jmp_type == JMP_J) begin
            c = CAUSE_J;
        end else if (jmp_type == JMP_JAL) begin
            c = CAUSE_JAL;
        end
        return c;
    endfunction

endpackage

// File: rtl/jump_redirect_ctrl_ras.sv
// jctrl_ras: circular return-address stack.
// Push writes at the pointer and advances it; pushing when full wraps and
// overwrites the oldest entry while the count stays at RAS_DEPTH.
// Pop steps the pointer back; popping an empty stack changes nothing.
// Only instantiated when JCTRL_RAS_EN is defined.
module jctrl_ras #(
    parameter int ADDR_W    = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  top_idx;

    // Top of stack sits one slot behind the write pointer.
    always_comb begin
        top_idx = ptr - 1'b1;
        top     = mem[top_idx];
        empty   = (count == '0);
        full    = (count == CNT_MAX);
    end

    // Pointer, occupancy and storage update on push/pop; reset empties the stack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[ptr] <= din;
            ptr      <= ptr + 1'b1;
            if (count != CNT_MAX) begin
                count <= count + 1'b1;
            end
        end else if (pop && (count != '0)) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/jump_redirect_ctrl.sv
// jump_redirect_ctrl: registered jump/redirect controller.
// Accepts JR (decoded from {ula_opcode, func}) and J/JAL (from jmp_type),
// issues a one-cycle redirect, holds flush for FLUSH_CYCLES cycles and
// produces the JAL link write. Every output comes straight from a flop.
// Optional feature macro: JCTRL_RAS_EN adds a return-address stack that
// flags JR targets not matching the last pushed JAL return address.
module jump_redirect_ctrl
    import jctrl_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int FLUSH_CYCLES = 1,
    parameter int RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              stall_in,
    input  logic [1:0]        ula_opcode,
    input  logic [3:0]        func,
    input  logic [1:0]        jmp_type,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] rs_value,
    input  logic [ADDR_W-1:0] pc_plus1,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              busy,
    output logic              JR_control,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_data,
    output logic              ras_miss
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e            state;
    logic [CNT_W-1:0]  flush_cnt;
    cause_e            cause_d;
    logic              accept;
    logic [ADDR_W-1:0] target_d;

    // Decode the instruction in decode and decide whether it is taken this cycle.
    always_comb begin
        cause_d  = decode_cause(ula_opcode, func, jmp_type);
        accept   = (state == ST_IDLE) && valid_in && !stall_in && (cause_d != CAUSE_NONE);
        target_d = (cause_d == CAUSE_JR) ? rs_value : jump_target;
    end

    // Redirect FSM; one-shot outputs live only in REDIRECT, flush/busy span the whole window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            flush_cnt   <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            flush       <= 1'b0;
            busy        <= 1'b0;
            JR_control  <= 1'b0;
            link_we     <= 1'b0;
            link_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_REDIRECT;
                        redirect    <= 1'b1;
                        redirect_pc <= target_d;
                        flush       <= 1'b1;
                        busy        <= 1'b1;
                        JR_control  <= (cause_d == CAUSE_JR);
                        link_we     <= (cause_d == CAUSE_JAL);
                        link_data   <= (cause_d == CAUSE_JAL) ? pc_plus1 : '0;
                    end
                end
                ST_REDIRECT: begin
                    redirect    <= 1'b0;
                    redirect_pc <= '0;
                    JR_control  <= 1'b0;
                    link_we     <= 1'b0;
                    link_data   <= '0;
                    if (FLUSH_CYCLES > 1) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end else begin
                        state <= ST_IDLE;
                        flush <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt <= CNT_ONE) begin
                        state     <= ST_IDLE;
                        flush_cnt <= '0;
                        flush     <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    flush_cnt <= '0;
                    flush     <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef JCTRL_RAS_EN
    logic              ras_push;
    logic              ras_pop;
    logic              ras_empty;
    logic              unused_ras_full;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_miss_q;

    // JAL pushes its return address, JR pops the prediction it is checked against.
    always_comb begin
        ras_push = accept && (cause_d == CAUSE_JAL);
        ras_pop  = accept && (cause_d == CAUSE_JR);
    end

    jctrl_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_plus1),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (unused_ras_full)
    );

    // Miss flag is registered alongside the redirect and is only ever high in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ras_miss_q <= 1'b0;
        end else if (ras_pop) begin
            ras_miss_q <= ras_empty || (ras_top != rs_value);
        end else begin
            ras_miss_q <= 1'b0;
        end
    end

    assign ras_miss = ras_miss_q;
`else
    assign ras_miss = 1'b0;
`endif

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Testbench for jump_redirect_ctrl: three instances (FLUSH_CYCLES 1, 3, 4)
// share one stimulus stream. A table of directed vectors runs on the
// FLUSH_CYCLES=3 instance; short hand sequences cover the other two.
module tb_jump_redirect_ctrl;

    localparam int ADDR_W = 8;
`ifdef JCTRL_RAS_EN
    localparam logic RAS_ON = 1'b1;
`else
    localparam logic RAS_ON = 1'b0;
`endif

    typedef struct packed {
        logic        redirect;
        logic [7:0]  redirect_pc;
        logic        flush;
        logic        busy;
        logic        jr_control;
        logic        link_we;
        logic [7:0]  link_data;
        logic        ras_miss;
    } outs_t;

    typedef struct {
        logic        valid;
        logic        stall;
        logic [1:0]  ula;
        logic [3:0]  fn;
        logic [1:0]  jt;
        logic [7:0]  tgt;
        logic [7:0]  rs;
        logic [7:0]  pc1;
        outs_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic       stall_in;
    logic [1:0] ula_opcode;
    logic [3:0] func;
    logic [1:0] jmp_type;
    logic [7:0] jump_target;
    logic [7:0] rs_value;
    logic [7:0] pc_plus1;

    logic       d1_redirect, d1_flush, d1_busy, d1_jr, d1_lwe, d1_miss;
    logic [7:0] d1_pc, d1_ld;
    logic       d3_redirect, d3_flush, d3_busy, d3_jr, d3_lwe, d3_miss;
    logic [7:0] d3_pc, d3_ld;
    logic       d4_redirect, d4_flush, d4_busy, d4_jr, d4_lwe, d4_miss;
    logic [7:0] d4_pc, d4_ld;

    outs_t o1, o3, o4;
    assign o1 = {d1_redirect, d1_pc, d1_flush, d1_busy, d1_jr, d1_lwe, d1_ld, d1_miss};
    assign o3 = {d3_redirect, d3_pc, d3_flush, d3_busy, d3_jr, d3_lwe, d3_ld, d3_miss};
    assign o4 = {d4_redirect, d4_pc, d4_flush, d4_busy, d4_jr, d4_lwe, d4_ld, d4_miss};

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    jump_redirect_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(1), .RAS_DEPTH(2)) u_fc1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .stall_in(stall_in),
        .ula_opcode(ula_opcode), .func(func), .jmp_type(jmp_type),
        .jump_target(jump_target), .rs_value(rs_value), .pc_plus1(pc_plus1),
        .redirect(d1_redirect), .redirect_pc(d1_pc), .flush(d1_flush), .busy(d1_busy),
        .JR_control(d1_jr), .link_we(d1_lwe), .link_data(d1_ld), .ras_miss(d1_miss)
    );

    jump_redirect_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(3), .RAS_DEPTH(2)) u_fc3 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .stall_in(stall_in),
        .ula_opcode(ula_opcode), .func(func), .jmp_type(jmp_type),
        .jump_target(jump_target), .rs_value(rs_value), .pc_plus1(pc_plus1),
        .redirect(d3_redirect), .redirect_pc(d3_pc), .flush(d3_flush), .busy(d3_busy),
        .JR_control(d3_jr), .link_we(d3_lwe), .link_data(d3_ld), .ras_miss(d3_miss)
    );

    jump_redirect_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(4), .RAS_DEPTH(2)) u_fc4 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .stall_in(stall_in),
        .ula_opcode(ula_opcode), .func(func), .jmp_type(jmp_type),
        .jump_target(jump_target), .rs_value(rs_value), .pc_plus1(pc_plus1),
        .redirect(d4_redirect), .redirect_pc(d4_pc), .flush(d4_flush), .busy(d4_busy),
        .JR_control(d4_jr), .link_we(d4_lwe), .link_data(d4_ld), .ras_miss(d4_miss)
    );

    // Build an expected-output record.
    function automatic outs_t mo(input logic r, input logic [7:0] pc, input logic f,
                                 input logic b, input logic j, input logic lw,
                                 input logic [7:0] ld, input logic m);
        outs_t o;
        o = {r, pc, f, b, j, lw, ld, m};
        return o;
    endfunction

    // Build a stimulus record.
    function automatic vec_t mkv(input logic v, input logic s, input logic [1:0] u,
                                 input logic [3:0] f, input logic [1:0] jt,
                                 input logic [7:0] tgt, input logic [7:0] rs,
                                 input logic [7:0] pc1, input outs_t e);
        vec_t x;
        x.valid = v; x.stall = s; x.ula = u; x.fn = f; x.jt = jt;
        x.tgt = tgt; x.rs = rs; x.pc1 = pc1; x.exp = e;
        return x;
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("redirect=%0b pc=%h flush=%0b busy=%0b jr=%0b link_we=%0b link_data=%h ras_miss=%0b",
                         o.redirect, o.redirect_pc, o.flush, o.busy, o.jr_control,
                         o.link_we, o.link_data, o.ras_miss);
    endfunction

    // Drive one vector's inputs and advance one clock; outputs are sampled 1ns after the edge.
    task automatic applyStimulus(input vec_t v);
        valid_in    = v.valid;
        stall_in    = v.stall;
        ula_opcode  = v.ula;
        func        = v.fn;
        jmp_type    = v.jt;
        jump_target = v.tgt;
        rs_value    = v.rs;
        pc_plus1    = v.pc1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic doReset();
        reset       = 1'b1;
        valid_in    = 1'b0;
        stall_in    = 1'b0;
        ula_opcode  = 2'b01;
        func        = 4'h3;
        jmp_type    = 2'b00;
        jump_target = '0;
        rs_value    = '0;
        pc_plus1    = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t  vecs [17];
    outs_t zero_o, fb_o;
    vec_t  idle_v;

    initial begin
        zero_o = mo(0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        fb_o   = mo(0, 8'h00, 1, 1, 0, 0, 8'h00, 0);
        idle_v = mkv(0, 0, 2'b01, 4'h3, 2'b00, 8'h00, 8'h00, 8'h00, zero_o);

        // FLUSH_CYCLES=3 instance; each record = inputs before the edge, outputs after it.
        vecs[0]  = mkv(0, 0, 2'b01, 4'h3, 2'b00, 8'h00, 8'h00, 8'h00, zero_o);
        vecs[1]  = mkv(1, 0, 2'b01, 4'h3, 2'b10, 8'h40, 8'h99, 8'h11, mo(1, 8'h40, 1, 1, 0, 1, 8'h11, 0));
        vecs[2]  = mkv(1, 0, 2'b01, 4'h3, 2'b01, 8'h22, 8'h00, 8'h00, fb_o);
        vecs[3]  = mkv(1, 0, 2'b01, 4'h3, 2'b01, 8'h22, 8'h00, 8'h00, fb_o);
        vecs[4]  = mkv(1, 1, 2'b01, 4'h3, 2'b01, 8'h22, 8'h00, 8'h00, zero_o);
        vecs[5]  = mkv(1, 1, 2'b01, 4'h3, 2'b01, 8'h22, 8'h00, 8'h00, zero_o);
        vecs[6]  = mkv(1, 0, 2'b01, 4'h3, 2'b01, 8'h22, 8'h00, 8'h00, mo(1, 8'h22, 1, 1, 0, 0, 8'h00, 0));
        vecs[7]  = mkv(0, 0, 2'b01, 4'h3, 2'b00, 8'h00, 8'h00, 8'h00, fb_o);
        vecs[8]  = mkv(0, 0, 2'b01, 4'h3, 2'b00, 8'h00, 8'h00, 8'h00, fb_o);
        vecs[9]  = mkv(0, 0, 2'b01, 4'h3, 2'b00, 8'h00, 8'h00, 8'h00, zero_o);
        vecs[10] = mkv(1, 0, 2'b00, 4'h0, 2'b10, 8'h55, 8'h3C, 8'h00, mo(1, 8'h3C, 1, 1, 1, 0, 8'h00, RAS_ON));
        vecs[11] = mkv(0, 0, 2'b01, 4'h3, 2'b00, 8'h00, 8'h00, 8'h00, fb_o);
        vecs[12] = mkv(0, 0, 2'b01, 4'h3, 2'b00, 8'h00, 8'h00, 8'h00, fb_o);
        vecs[13] = mkv(0, 0, 2'b01, 4'h3, 2'b00, 8'h00, 8'h00, 8'h00, zero_o);
        vecs[14] = mkv(1, 0, 2'b01, 4'h3, 2'b11, 8'h66, 8'h00, 8'h00, zero_o);
        vecs[15] = mkv(0, 0, 2'b00, 4'h0, 2'b00, 8'h00, 8'h44, 8'h00, zero_o);
        vecs[16] = mkv(1, 0, 2'b00, 4'h1, 2'b00, 8'h00, 8'h44, 8'h00, zero_o);

        doReset();
        checkOutput("reset_fc1", o1, zero_o);
        checkOutput("reset_fc3", o3, zero_o);
        checkOutput("reset_fc4", o4, zero_o);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), o3, vecs[i].exp);
        end

        // JR with FLUSH_CYCLES=1: one redirect cycle, then everything drops.
        doReset();
        applyStimulus(idle_v);
        applyStimulus(mkv(1, 0, 2'b00, 4'h0, 2'b00, 8'h00, 8'h3C, 8'h00, zero_o));
        checkOutput("fc1_jr_redirect", o1, mo(1, 8'h3C, 1, 1, 1, 0, 8'h00, RAS_ON));
        applyStimulus(idle_v);
        checkOutput("fc1_jr_done", o1, zero_o);

        // Reset in the middle of a FLUSH_CYCLES=4 flush, then a JR after release.
        doReset();
        applyStimulus(mkv(1, 0, 2'b01, 4'h3, 2'b01, 8'h50, 8'h00, 8'h00, zero_o));
        applyStimulus(idle_v);
        applyStimulus(idle_v);
        checkOutput("fc4_in_flush", o4, fb_o);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("fc4_async_reset", o4, zero_o);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(mkv(1, 0, 2'b00, 4'h0, 2'b00, 8'h00, 8'h77, 8'h00, zero_o));
        checkOutput("fc4_jr_after_reset", o4, mo(1, 8'h77, 1, 1, 1, 0, 8'h00, RAS_ON));
        applyStimulus(idle_v);
        applyStimulus(idle_v);
        applyStimulus(idle_v);
        checkOutput("fc4_last_flush", o4, fb_o);
        applyStimulus(idle_v);
        checkOutput("fc4_flush_end", o4, zero_o);

        // Return-address stack of depth 2 on the FLUSH_CYCLES=1 instance.
        doReset();
        applyStimulus(mkv(1, 0, 2'b01, 4'h3, 2'b10, 8'h30, 8'h00, 8'h05, zero_o));
        checkOutput("ras_jal5", o1, mo(1, 8'h30, 1, 1, 0, 1, 8'h05, 0));
        applyStimulus(idle_v);
        applyStimulus(mkv(1, 0, 2'b01, 4'h3, 2'b10, 8'h30, 8'h00, 8'h06, zero_o));
        applyStimulus(idle_v);
        applyStimulus(mkv(1, 0, 2'b01, 4'h3, 2'b10, 8'h30, 8'h00, 8'h07, zero_o));
        applyStimulus(idle_v);
        applyStimulus(mkv(1, 0, 2'b00, 4'h0, 2'b00, 8'h00, 8'h07, 8'h00, zero_o));
        checkOutput("ras_jr07", o1, mo(1, 8'h07, 1, 1, 1, 0, 8'h00, 0));
        applyStimulus(idle_v);
        applyStimulus(mkv(1, 0, 2'b00, 4'h0, 2'b00, 8'h00, 8'h06, 8'h00, zero_o));
        checkOutput("ras_jr06", o1, mo(1, 8'h06, 1, 1, 1, 0, 8'h00, 0));
        applyStimulus(idle_v);
        applyStimulus(mkv(1, 0, 2'b00, 4'h0, 2'b00, 8'h00, 8'h05, 8'h00, zero_o));
        checkOutput("ras_jr_empty", o1, mo(1, 8'h05, 1, 1, 1, 0, 8'h00, RAS_ON));
        applyStimulus(idle_v);
        checkOutput("ras_miss_clear", o1, zero_o);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
